muldiv_sequencer: RTL

Multi-cycle sequencer for the RV32M multiply/divide instructions. It sits beside the integer ALU in the EX stage: it takes operands and func3 from the ID/EX register, iterates a shared shift-add/restoring-subtract datapath for WIDTH cycles, and stalls the pipeline until the result is ready. It then hands one result to the EX/MEM mux, which selects it when the decoder flags a funct7 = 0000001 instruction.

---
 rtl/muldiv_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide engine for the EX stage.
// One shift-add / restoring-subtract datapath is reused for all eight ops.
// The pipeline is stalled until a single registered result is handed back.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             f3_q, f3_d;
  // Multiply: opa = multiplicand (shifts left), opb = multiplier (shifts right).
  // Divide:   opa = divisor,                    opb = dividend -> quotient.
  logic [2*WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]       opb_q, opb_d;
  // Multiply: 2*WIDTH product. Divide: partial remainder in acc[WIDTH:0].
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   neg_a_q, neg_a_d;
  logic                   neg_b_q, neg_b_d;
  logic [WIDTH-1:0]       result_q, result_d;

  // Two's-complement negate when en is set, WIDTH bits.
  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // Two's-complement negate when en is set, 2*WIDTH bits.
  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // Operand decode, valid while in PREP (raw operands still sit in opa/opb).
  logic                   is_div;
  logic                   a_signed, b_signed;
  logic [WIDTH-1:0]       a_raw, b_raw;
  logic                   a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic                   div_zero, div_ovf;

  assign is_div   = f3_q[2];
  assign a_signed = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
  assign b_signed = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
  assign a_raw    = opa_q[WIDTH-1:0];
  assign b_raw    = opb_q;
  assign a_neg    = a_signed && a_raw[WIDTH-1];
  assign b_neg    = b_signed && b_raw[WIDTH-1];
  assign a_mag    = cneg_w(a_raw, a_neg);
  assign b_mag    = cneg_w(b_raw, b_neg);
  assign div_zero = (b_raw == '0);
  assign div_ovf  = ((f3_q == 3'b100) || (f3_q == 3'b110)) &&
                    (a_raw == {1'b1, {(WIDTH-1){1'b0}}}) && (b_raw == '1);

  // Restoring-divide step: shift in the next dividend bit, trial-subtract.
  // One extra bit on the trial difference exposes the borrow.
  logic [WIDTH:0]         rem_shift;
  logic [WIDTH+1:0]       rem_trial;
  logic                   q_bit;

  assign rem_shift = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
  assign rem_trial = {1'b0, rem_shift} - {2'b00, opa_q[WIDTH-1:0]};
  assign q_bit     = ~rem_trial[WIDTH+1];

  // Sign fix-up of the unsigned iteration results.
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quot_fix, rem_fix;
  logic [WIDTH-1:0]       fix_sel;

  assign prod_fix = cneg_2w(acc_q, neg_a_q ^ neg_b_q);
  assign quot_fix = cneg_w(opb_q, neg_a_q ^ neg_b_q);
  assign rem_fix  = cneg_w(acc_q[WIDTH-1:0], neg_a_q);

  // Pick the architectural result for the latched func3.
  always_comb begin
    fix_sel = prod_fix[WIDTH-1:0];
    case (f3_q)
      3'b000:                 fix_sel = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_sel = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_sel = quot_fix;
      default:                fix_sel = rem_fix;
    endcase
  end

  // Next-state and datapath update; flush always wins and keeps result.
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          f3_d    = func3;
          opa_d   = {{WIDTH{1'b0}}, a};
          opb_d   = b;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        neg_a_d = a_neg;
        neg_b_d = b_neg;
        acc_d   = '0;
        cnt_d   = CNT_LOAD;
        if (is_div) begin
          opa_d = {{WIDTH{1'b0}}, b_mag};
          opb_d = a_mag;
        end else begin
          opa_d = {{WIDTH{1'b0}}, a_mag};
          opb_d = b_mag;
        end
        if (is_div && div_zero) begin
          result_d = f3_q[1] ? a_raw : '1;
          state_d  = ST_DONE;
        end else if (is_div && div_ovf) begin
          result_d = f3_q[1] ? '0 : a_raw;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        if (is_div) begin
          acc_d = {{(WIDTH-1){1'b0}}, (q_bit ? rem_trial[WIDTH:0] : rem_shift)};
          opb_d = {opb_q[WIDTH-2:0], q_bit};
        end else begin
          if (opb_q[0]) begin
            acc_d = acc_q + opa_q;
          end
          opa_d = {opa_q[2*WIDTH-2:0], 1'b0};
          opb_d = {1'b0, opb_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FIX: begin
        result_d = fix_sel;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      f3_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_q <= result_d;
    end
  end

  assign stall  = ((state_q == ST_IDLE) && start && !flush) ||
                  (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule
